// File: rtl/led_matrix_scroller.sv
// Scrolling-text engine: buffers character codes, fetches each glyph from the
// external decoder and scrolls it right-to-left into an 8x8 frame.
module led_matrix_scroller #(
  parameter int STEP_CYCLES = 5000000,
  parameter int GAP         = 1,
  parameter int DEPTH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [7:0]  glyph_code,
  input  logic [63:0] glyph_array,
  output logic [63:0] array,
  output logic        busy,
  output logic        step
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [2:0]    GAP_LAST  = 3'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    col_ptr, col_nxt;
  logic [2:0]    gap_cnt, gap_nxt;
  logic [2:0]    drain_cnt, drain_nxt;
  logic [63:0]   glyph_reg, glyph_nxt;
  logic [63:0]   array_q, array_nxt;
  logic [7:0]    glyph_col;

  // ---------------- character FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign char_ready = !full;
  assign push       = char_valid && !full;
  assign pop        = (state == S_LOAD) && !empty;
  assign glyph_code = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= char_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- scroll datapath helpers ----------------
  function automatic logic [63:0] shift_in(input logic [63:0] a, input logic [7:0] col);
    logic [63:0] s;
    s = a;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 7; c++) s[r*8+c] = a[r*8+c+1];
      s[r*8+7] = col[r];
    end
    return s;
  endfunction

  always_comb begin
    glyph_col = '0;
    for (int r = 0; r < 8; r++) glyph_col[r] = glyph_reg[{3'(r), col_ptr}];
  end

  // Timer only runs in the timed states; LOAD holds it so every glyph starts
  // a full step period after its load cycle.
  assign step = ((state == S_SHIFT) || (state == S_GAP) || (state == S_DRAIN)) &&
                en && (timer == STEP_LAST);
  assign busy  = (state != S_IDLE);
  assign array = array_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      col_ptr   <= '0;
      gap_cnt   <= '0;
      drain_cnt <= '0;
      glyph_reg <= '0;
      array_q   <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      col_ptr   <= col_nxt;
      gap_cnt   <= gap_nxt;
      drain_cnt <= drain_nxt;
      glyph_reg <= glyph_nxt;
      array_q   <= array_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    col_nxt   = col_ptr;
    gap_nxt   = gap_cnt;
    drain_nxt = drain_cnt;
    glyph_nxt = glyph_reg;
    array_nxt = array_q;

    if (state != S_IDLE && state != S_LOAD && en)
      timer_nxt = step ? '0 : timer + 1'b1;

    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (!empty && en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        glyph_nxt = glyph_array;
        col_nxt   = '0;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (step) begin
          array_nxt = shift_in(array_q, glyph_col);
          if (col_ptr == 3'd7) begin
            if (GAP == 0) begin
              if (!empty) state_nxt = S_LOAD;
              else begin
                state_nxt = S_DRAIN;
                drain_nxt = '0;
              end
            end else begin
              state_nxt = S_GAP;
              gap_nxt   = '0;
            end
          end else begin
            col_nxt = col_ptr + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (step) begin
          array_nxt = shift_in(array_q, 8'h00);
          if (gap_cnt == GAP_LAST) begin
            if (!empty) state_nxt = S_LOAD;
            else begin
              state_nxt = S_DRAIN;
              drain_nxt = '0;
            end
          end else begin
            gap_nxt = gap_cnt + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (step) begin
          array_nxt = shift_in(array_q, 8'h00);
          if (!empty) state_nxt = S_LOAD;
          else if (drain_cnt == 3'd7) begin
            state_nxt = S_IDLE;
            array_nxt = '0;
          end else begin
            drain_nxt = drain_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_matrix_scroller.sv
// Scoreboard bench for led_matrix_scroller: expected frames are queued as
// characters are issued and compared by a monitor after every scroll step.
module tb_led_matrix_scroller;

  localparam logic [63:0] GLYPH = 64'h0101010101010101;

  logic        clk = 1'b0;
  logic        rst, en, char_valid;
  logic [7:0]  char_in, glyph_code;
  logic        char_ready, busy, step;
  logic [63:0] glyph_array, array;

  int tests = 0;
  int fails = 0;
  int step_count = 0;
  logic [63:0] exp_q[$];
  logic pend = 1'b0;

  // Bench decoder: every code maps to "column 0 lit".
  assign glyph_array = GLYPH;

  always #5 clk = ~clk;

  led_matrix_scroller #(.STEP_CYCLES(4), .GAP(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .glyph_code(glyph_code), .glyph_array(glyph_array),
    .array(array), .busy(busy), .step(step)
  );

  function automatic logic [63:0] rowfill(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic glyph_frames();
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b = 8'h80 >> k;
      exp_q.push_back(rowfill(b));
    end
    exp_q.push_back(64'h0);
  endtask

  task automatic zeros(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(64'h0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    tick();
    tick();
    while (busy && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic wait_steps(input string name, input int nsteps, input int budget);
    int n, seen;
    n = 0;
    seen = 0;
    while (seen < nsteps && n < budget) begin
      tick();
      n++;
      if (step) seen++;
    end
    tests++;
    if (seen < nsteps) begin
      fails++;
      $display("FAIL %s_step_timeout: saw %0d steps, required %0d", name, seen, nsteps);
    end
  endtask

  // Monitor: a step seen at one negedge means the frame updates on the next
  // posedge, so the comparison happens at the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_step: array %h, required no step", array);
        end else begin
          check("frame", array, exp_q.pop_front());
        end
      end
      pend = (step === 1'b1) && !rst;
      if (pend) step_count++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc0, n, nstep, nchg;
    logic idle_seen;
    rst = 1'b1; en = 1'b0; char_valid = 1'b0; char_in = 8'h00;
    repeat (3) tick();

    // 1: reset state
    check("reset_array", array, 64'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", char_ready, 1'b1);
    check("reset_step", step, 1'b0);
    check("reset_code", glyph_code, 8'h00);
    rst = 1'b0;
    tick();

    // 2: single glyph, first-step latency, full drain
    sc0 = step_count;
    glyph_frames();
    zeros(8);
    en = 1'b1; char_in = 8'h41; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    check("t2_head", glyph_code, 8'h41);
    check("t2_idle", busy, 1'b0);
    tick();
    check("t2_load_busy", busy, 1'b1);
    check("t2_load_code", glyph_code, 8'h41);
    tick();
    check("t2_popped", glyph_code, 8'h00);
    n = 0;
    while (!step && n < 20) begin tick(); n++; end
    check("t2_first_step_lat", n, 3);
    wait_idle("t2", 300);
    check("t2_steps", step_count - sc0, 17);
    tick();
    check("t2_queue", exp_q.size(), 0);

    // 3: fill FIFO while frozen, overflow ignored
    en = 1'b0;
    sc0 = step_count;
    for (int i = 0; i < 5; i++) begin
      char_in = 8'h10 + 8'(i); char_valid = 1'b1;
      tick();
      if (i == 2) check("t3_not_full", char_ready, 1'b1);
      if (i == 3) check("t3_full", char_ready, 1'b0);
    end
    char_valid = 1'b0;
    check("t3_head", glyph_code, 8'h10);
    for (int i = 0; i < 4; i++) glyph_frames();
    zeros(8);
    en = 1'b1;
    wait_idle("t3", 600);
    check("t3_steps", step_count - sc0, 44);
    tick();
    check("t3_queue", exp_q.size(), 0);

    // 4/5: back-to-back glyphs, freeze after step 3
    en = 1'b0;
    char_in = 8'h20; char_valid = 1'b1; tick();
    char_in = 8'h21; tick();
    char_valid = 1'b0;
    sc0 = step_count;
    glyph_frames(); glyph_frames(); zeros(8);
    en = 1'b1;
    wait_steps("t5", 3, 100);
    tick();
    en = 1'b0;
    check("t5_frozen_start", array, rowfill(8'h20));
    nstep = 0; nchg = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step) nstep++;
      if (array !== rowfill(8'h20)) nchg++;
    end
    check("t5_freeze_step", nstep, 0);
    check("t5_freeze_array", nchg, 0);
    en = 1'b1;
    n = 0;
    while (!step && n < 20) begin tick(); n++; end
    check("t5_resume_lat", n, 3);
    tick();
    check("t5_step4", array, rowfill(8'h10));
    wait_idle("t5", 400);
    check("t5_steps", step_count - sc0, 26);
    tick();
    check("t5_queue", exp_q.size(), 0);

    // 6: push during DRAIN (drain_cnt=3) reloads at the next step
    sc0 = step_count;
    en = 1'b1; char_in = 8'h30; char_valid = 1'b1; tick();
    char_valid = 1'b0;
    glyph_frames(); zeros(4);
    wait_steps("t6", 12, 200);
    tick();
    char_in = 8'h31; char_valid = 1'b1; tick();
    char_valid = 1'b0;
    glyph_frames(); zeros(8);
    idle_seen = 1'b0; n = 0;
    while (step_count - sc0 < 14 && n < 100) begin
      tick();
      if (!busy) idle_seen = 1'b1;
      n++;
    end
    check("t6_no_idle", idle_seen, 1'b0);
    wait_idle("t6", 400);
    check("t6_steps", step_count - sc0, 30);
    tick();
    check("t6_queue", exp_q.size(), 0);

    // 6b: reset mid-SHIFT discards frame and FIFO
    en = 1'b1; char_in = 8'h40; char_valid = 1'b1; tick();
    char_in = 8'h41; tick();
    char_valid = 1'b0;
    exp_q.push_back(rowfill(8'h80));
    exp_q.push_back(rowfill(8'h40));
    exp_q.push_back(rowfill(8'h20));
    wait_steps("rst", 3, 100);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_array", array, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", char_ready, 1'b1);
    check("rst_code", glyph_code, 8'h00);
    rst = 1'b0;
    sc0 = step_count;
    repeat (20) tick();
    check("rst_stays_idle", busy, 1'b0);
    check("rst_no_steps", step_count - sc0, 0);
    check("rst_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
